// File: rtl/slot_reel_ctrl.sv
// Three-reel spin controller: LFSR-seeded stop segments, sequential reel stops, win scoring.
// Optional SLOT_HOLD_EN adds a 3-bit hold input that freezes selected reels for a game.
module slot_reel_ctrl #(
   parameter int unsigned NUM_SYMBOLS = 10,
   parameter int unsigned SPIN_BASE   = 8,
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned JACKPOT_SYM = 7
) (
   input  logic       clk,
   input  logic       reset,
`ifdef SLOT_HOLD_EN
   input  logic [2:0] hold,
`endif
   input  logic       start,
   input  logic [3:0] lfsr_in,
   output logic       lfsr_enable,
   output logic [3:0] reel0,
   output logic [3:0] reel1,
   output logic [3:0] reel2,
   output logic       busy,
   output logic       done,
   output logic [1:0] win
);

   localparam logic [3:0] SYM_MAX   = 4'(NUM_SYMBOLS - 1);
   localparam logic [3:0] JACKPOT   = 4'(JACKPOT_SYM);
   localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

   typedef enum logic [2:0] {IDLE, SPIN0, SPIN1, SPIN2, EVAL} state_t;

   state_t     state, state_nxt;
   logic [7:0] presc, presc_nxt;
   logic [5:0] seg, seg_nxt;
   logic [3:0] reel0_nxt, reel1_nxt, reel2_nxt;
   logic       busy_nxt, done_nxt;
   logic [1:0] win_nxt;
   logic [2:0] spin_mask;
   logic [2:0] hold_r;
   logic [5:0] seg_load;
   logic       tick;
   logic       eq01, eq12, eq02;

   function automatic logic [3:0] step_sym(input logic [3:0] s);
      return (s == SYM_MAX) ? 4'd0 : s + 4'd1;
   endfunction

   assign lfsr_enable = busy;
   assign seg_load    = 6'(SPIN_BASE) + {2'b00, lfsr_in};
   assign tick        = (presc == TICK_LAST);
   assign eq01        = (reel0 == reel1);
   assign eq12        = (reel1 == reel2);
   assign eq02        = (reel0 == reel2);

`ifdef SLOT_HOLD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      hold_r <= '0;
      else if (state == IDLE && start) hold_r <= hold;
   end
`else
   assign hold_r = '0;
`endif

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      seg_nxt   = seg;
      reel0_nxt = reel0;
      reel1_nxt = reel1;
      reel2_nxt = reel2;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      win_nxt   = win;
      spin_mask = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SPIN0;
               busy_nxt  = 1'b1;
               win_nxt   = '0;
               presc_nxt = '0;
               seg_nxt   = seg_load;
            end
         end
         SPIN0, SPIN1, SPIN2: begin
            presc_nxt = tick ? '0 : presc + 8'd1;
            case (state)
               SPIN0:   spin_mask = 3'b111;
               SPIN1:   spin_mask = 3'b110;
               default: spin_mask = 3'b100;
            endcase
            spin_mask = spin_mask & ~hold_r;
            if (tick) begin
               if (spin_mask[0]) reel0_nxt = step_sym(reel0);
               if (spin_mask[1]) reel1_nxt = step_sym(reel1);
               if (spin_mask[2]) reel2_nxt = step_sym(reel2);
               seg_nxt = seg - 6'd1;
               // last step of a segment still advances, then the next reel's length is sampled
               if (seg == 6'd1) begin
                  seg_nxt = seg_load;
                  case (state)
                     SPIN0:   state_nxt = SPIN1;
                     SPIN1:   state_nxt = SPIN2;
                     default: state_nxt = EVAL;
                  endcase
               end
            end
         end
         EVAL: begin
            if (eq01 && eq12 && reel0 == JACKPOT) win_nxt = 2'b11;
            else if (eq01 && eq12)                win_nxt = 2'b10;
            else if (eq01 || eq12 || eq02)        win_nxt = 2'b01;
            else                                  win_nxt = 2'b00;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         presc <= '0;
         seg   <= '0;
         reel0 <= '0;
         reel1 <= '0;
         reel2 <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         win   <= '0;
      end else begin
         state <= state_nxt;
         presc <= presc_nxt;
         seg   <= seg_nxt;
         reel0 <= reel0_nxt;
         reel1 <= reel1_nxt;
         reel2 <= reel2_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         win   <= win_nxt;
      end
   end

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed self-checking bench for slot_reel_ctrl (default parameters, lfsr_in driven directly).
module tb_slot_reel_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] lfsr_in;
   logic       lfsr_enable;
   logic [3:0] reel0, reel1, reel2;
   logic       busy, done;
   logic [1:0] win;
`ifdef SLOT_HOLD_EN
   logic [2:0] hold;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;

   slot_reel_ctrl #(
      .NUM_SYMBOLS(10),
      .SPIN_BASE  (8),
      .TICK_DIV   (4),
      .JACKPOT_SYM(7)
   ) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef SLOT_HOLD_EN
      .hold       (hold),
`endif
      .start      (start),
      .lfsr_in    (lfsr_in),
      .lfsr_enable(lfsr_enable),
      .reel0      (reel0),
      .reel1      (reel1),
      .reel2      (reel2),
      .busy       (busy),
      .done       (done),
      .win        (win)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL timeout simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
   endtask

   // Drives one game with per-segment LFSR values; returns just after the done edge.
   task automatic run_game(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      int la, lb, lc;
      la = 8 + int'(a);
      lb = 8 + int'(b);
      lc = 8 + int'(c);
      lfsr_in = a;
      start   = 1'b1;
      step(1);
      start   = 1'b0;
      step(4 * la - 1);
      lfsr_in = b;
      step(4 * lb);
      lfsr_in = c;
      step(4 * lc + 2);
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      start   = 1'b0;
      lfsr_in = 4'd0;
`ifdef SLOT_HOLD_EN
      hold    = 3'b000;
`endif
      step(2);
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h000) $display("FAIL reset_reels got %h exp 000", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if ({busy, done, lfsr_enable} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {busy, done, lfsr_enable}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b00) $display("FAIL reset_win got %b exp 00", win); else pass_cnt++;
      reset = 1'b1;
      step(3);
      chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else pass_cnt++;
   endtask

   task automatic test_basic();
      lfsr_in = 4'd3;
      start   = 1'b1;
      step(1);
      start   = 1'b0;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else pass_cnt++;
      chk_cnt++; if (lfsr_enable !== 1'b1) $display("FAIL basic_lfsr_en got %b exp 1", lfsr_enable); else pass_cnt++;
      step(3);
      chk_cnt++; if (reel0 !== 4'd0) $display("FAIL basic_pre_tick got %0d exp 0", reel0); else pass_cnt++;
      step(1);
      chk_cnt++; if (reel0 !== 4'd1) $display("FAIL basic_first_tick got %0d exp 1", reel0); else pass_cnt++;
      step(127);
      chk_cnt++; if (reel2 !== 4'd2) $display("FAIL basic_edge131_reel2 got %0d exp 2", reel2); else pass_cnt++;
      step(1);
      chk_cnt++; if (reel2 !== 4'd3) $display("FAIL basic_final_tick_reel2 got %0d exp 3", reel2); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL basic_eval_done got %b exp 0", done); else pass_cnt++;
      step(1);
      chk_cnt++; if (done !== 1'b1) $display("FAIL basic_done got %b exp 1", done); else pass_cnt++;
      chk_cnt++; if ({busy, lfsr_enable} !== 2'b00) $display("FAIL basic_end_flags got %b exp 00", {busy, lfsr_enable}); else pass_cnt++;
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h123) $display("FAIL basic_reels got %h exp 123", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b00) $display("FAIL basic_win got %b exp 00", win); else pass_cnt++;
      step(1);
      chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else pass_cnt++;
   endtask

   task automatic test_jackpot();
      do_reset();
      run_game(4'd9, 4'd2, 4'd2);
      chk_cnt++; if (done !== 1'b1) $display("FAIL jackpot_done got %b exp 1", done); else pass_cnt++;
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h777) $display("FAIL jackpot_reels got %h exp 777", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b11) $display("FAIL jackpot_win got %b exp 11", win); else pass_cnt++;
      step(5);
      chk_cnt++; if (win !== 2'b11) $display("FAIL jackpot_win_hold got %b exp 11", win); else pass_cnt++;
   endtask

   task automatic test_triple_pair();
      do_reset();
      run_game(4'd2, 4'd2, 4'd2);
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h000) $display("FAIL triple_reels got %h exp 000", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b10) $display("FAIL triple_win got %b exp 10", win); else pass_cnt++;
      do_reset();
      run_game(4'd2, 4'd2, 4'd3);
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h001) $display("FAIL pair_reels got %h exp 001", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b01) $display("FAIL pair_win got %b exp 01", win); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int done_seen, busy_low;
      done_seen = 0;
      busy_low  = 0;
      do_reset();
      lfsr_in = 4'd2;
      start   = 1'b1;
      step(1);
      for (int i = 1; i <= 120; i++) begin
         step(1);
         if (done === 1'b1) done_seen++;
         if (busy !== 1'b1) busy_low++;
      end
      chk_cnt++; if (done_seen !== 0) $display("FAIL b2b_early_done got %0d exp 0", done_seen); else pass_cnt++;
      chk_cnt++; if (busy_low !== 0) $display("FAIL b2b_busy_drop got %0d exp 0", busy_low); else pass_cnt++;
      step(1);
      chk_cnt++; if (done !== 1'b1) $display("FAIL b2b_done got %b exp 1", done); else pass_cnt++;
      chk_cnt++; if (win !== 2'b10) $display("FAIL b2b_win1 got %b exp 10", win); else pass_cnt++;
      step(1);
      start = 1'b0;
      chk_cnt++; if ({busy, done} !== 2'b10) $display("FAIL b2b_restart got %b exp 10", {busy, done}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b00) $display("FAIL b2b_win_clear got %b exp 00", win); else pass_cnt++;
      step(120);
      chk_cnt++; if (done !== 1'b0) $display("FAIL b2b_game2_early got %b exp 0", done); else pass_cnt++;
      step(1);
      chk_cnt++; if ({done, win} !== 3'b110) $display("FAIL b2b_game2_end got %b exp 110", {done, win}); else pass_cnt++;
   endtask

   task automatic test_reset_mid_game();
      int done_seen;
      done_seen = 0;
      lfsr_in = 4'd3;
      start   = 1'b1;
      step(1);
      start   = 1'b0;
      step(60);
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h155) $display("FAIL mid_reels got %h exp 155", {reel0, reel1, reel2}); else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h000) $display("FAIL mid_reset_reels got %h exp 000", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if ({busy, done, lfsr_enable, win} !== 5'b00000) $display("FAIL mid_reset_flags got %b exp 00000", {busy, done, lfsr_enable, win}); else pass_cnt++;
      step(2);
      reset = 1'b1;
      for (int i = 0; i < 150; i++) begin
         step(1);
         if (done === 1'b1) done_seen++;
      end
      chk_cnt++; if (done_seen !== 0) $display("FAIL mid_no_done got %0d exp 0", done_seen); else pass_cnt++;
      run_game(4'd3, 4'd3, 4'd3);
      chk_cnt++; if (done !== 1'b1) $display("FAIL mid_next_done got %b exp 1", done); else pass_cnt++;
      chk_cnt++; if ({reel0, reel1, reel2, win} !== 14'b0001_0010_0011_00) $display("FAIL mid_next_result got %h/%b exp 123/00", {reel0, reel1, reel2}, win); else pass_cnt++;
   endtask

`ifdef SLOT_HOLD_EN
   task automatic test_hold();
      hold = 3'b010;
      run_game(4'd3, 4'd3, 4'd3);
      hold = 3'b000;
      chk_cnt++; if (done !== 1'b1) $display("FAIL hold_done got %b exp 1", done); else pass_cnt++;
      chk_cnt++; if ({reel0, reel1, reel2} !== 12'h226) $display("FAIL hold_reels got %h exp 226", {reel0, reel1, reel2}); else pass_cnt++;
      chk_cnt++; if (win !== 2'b01) $display("FAIL hold_win got %b exp 01", win); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_jackpot();
      test_triple_pair();
      test_back_to_back();
      test_reset_mid_game();
`ifdef SLOT_HOLD_EN
      test_hold();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/slot_reel_ctrl.md
Name: slot_reel_ctrl

Overview:
- Three-reel spin controller, directly downstream of the 4-bit LFSR random source.
- Drives the LFSR enable while a game runs. Samples the LFSR output to set each reel's spin length.
- Stops the reels in sequence, then scores the result as no win, pair, triple or jackpot.
- Outputs feed the display/payout logic.

Parameters:
- NUM_SYMBOLS, 10: symbols per reel, values 0..NUM_SYMBOLS-1; legal range 2..16.
- SPIN_BASE, 8: minimum reel steps per stop segment; legal range 1..48.
- TICK_DIV, 4: clock cycles per reel step; legal range 1..255.
- JACKPOT_SYM, 7: symbol value that upgrades a triple to jackpot.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  game request; sampled each cycle, accepted only in IDLE.
- lfsr_in  in  4  random value from the LFSR.
- lfsr_enable  out  1  enable to the LFSR.
- reel0  out  4  symbol shown on reel 0.
- reel1  out  4  symbol shown on reel 1.
- reel2  out  4  symbol shown on reel 2.
- busy  out  1  game in progress.
- done  out  1  one-cycle pulse when the result is valid.
- win  out  2  00 none, 01 pair, 10 triple, 11 jackpot.

Behaviour:
- Reset (async assert, sync release): state IDLE; reel0/1/2=0, busy=0, done=0, win=00, lfsr_enable=0; prescaler=0, segment counter=0.
- States: IDLE, SPIN0, SPIN1, SPIN2, EVAL.
- lfsr_enable = busy (registered); the LFSR advances every cycle of a game.
- IDLE:
  - start=1 at an edge → state SPIN0, busy=1, win=00, prescaler=0.
  - Segment counter loaded with L = SPIN_BASE + lfsr_in (6-bit, zero-extended).
  - start while busy is ignored; no queueing.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - A tick occurs at each edge where the prescaler = TICK_DIV-1.
  - The first tick is therefore the TICK_DIV-th edge after the accept edge.
- On each tick, the spinning reels advance by +1, wrapping NUM_SYMBOLS-1 → 0:
  - SPIN0: all three reels spin.
  - SPIN1: reel1 and reel2 spin.
  - SPIN2: reel2 only.
- Segment counter decrements on each tick. When a tick takes it from 1 to 0:
  - That tick's reel advance still happens.
  - The lowest-numbered spinning reel freezes.
  - Counter reloads with SPIN_BASE + lfsr_in sampled that cycle.
  - State advances SPIN0→SPIN1→SPIN2→EVAL.
- Result: reel0 advances exactly L0 steps, reel1 L0+L1, reel2 L0+L1+L2.
- EVAL (exactly one cycle). At its exit edge:
  - Register win: 11 if all reels equal and = JACKPOT_SYM; 10 if all equal; 01 if any two equal; else 00.
  - done=1 for that one cycle; busy=0, lfsr_enable=0; state IDLE.
  - win holds until the next accepted start.
- start asserted in the same cycle that done=1: accepted (state is IDLE).
- Reels keep their values between games; each new game spins from the current positions.
- Reset mid-game: immediate return to reset values. No done pulse, no win update.
- Reel and counter arithmetic must never produce values ≥ NUM_SYMBOLS or overflow 6 bits within the legal parameter ranges.

Optional Feature:
- Macro SLOT_HOLD_EN.
- Defined:
  - Adds input port hold (3 bits), sampled only at the start-accept edge.
  - A held reel does not advance during that game. Segment timing is unchanged, so the held reel's stop segment still elapses.
  - Scoring is unchanged.
- Not defined:
  - No hold port.
  - Every reel spins in every game.

Test Plan (NUM_SYMBOLS=10, SPIN_BASE=8, TICK_DIV=4, JACKPOT_SYM=7; bench drives lfsr_in directly):
- Reset then lfsr_in=3 constant, start pulse → busy=1 and lfsr_enable=1 after the accept edge. Final tick at edge 132 after accept; done=1 after edge 133. reel0/1/2 = 1/2/3, win=00, busy=0.
- From reels 0/0/0: lfsr_in=9 for segment 0, 2 for segments 1 and 2 (L=17,10,10) → reels 7/7/7, win=11.
- From 0/0/0: lfsr_in=2,2,2 → reels 0/0/0, win=10. Then lfsr_in=2,2,3 from 0/0/0 (after reset) → 0/0/1, win=01.
- start pulsed every cycle during a game → no restart, exactly one done pulse. start in the done cycle → new game starts and win clears to 00.
- reset low during SPIN1 → all outputs immediately at reset values, no done. Next game behaves as in the first scenario.
- SLOT_HOLD_EN defined, reels at 1/2/3, hold=3'b010, lfsr_in=3 constant → reels 2/2/6 (reel1 unchanged), win=01.
